multiply_accumulate_pipe: RTL

- Parametrised successor to the team's pipelined multiply-add primitive.
- Adds four things: a per-sample accumulate mode, pipelined C alongside A/B, a registered output stage with rounding right-shift and saturation, and an overflow flag.
- Used as the MAC leaf for dot-product, FIR and matrix-row engines in the linear-algebra layer.
- Every operand is tagged with a valid bit that walks the pipeline under the global enable.

---
 rtl/multiply_accumulate_pipe.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/multiply_accumulate_pipe.sv
// multiply_accumulate_pipe: pipelined signed multiply-add / multiply-accumulate with rounding shift, saturation and overflow flag
//   mac_delay: valid-tagged register chain of depth D (D = 0 is a plain wire)
//   multiply_accumulate_pipe ports:
//     clk, reset (async, active low), enable (global advance, 0 freezes all state)
//     inReady/inLast/mode/A/B/C : sample, end-of-run tag, 0 = MADD / 1 = MACC, operands
//     outReady/earlyOutReady    : result valid / result valid on next enabled cycle
//     RES/overflow              : converted result and its clamp/wrap flag

module mac_delay #(
    parameter int W = 8,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         iv,
    input  logic [W-1:0] id,
    output logic         ov,
    output logic [W-1:0] od
);
    if (D == 0) begin : g_wire
        assign ov = iv;
        assign od = id;
    end else begin : g_reg
        logic         v [D];
        logic [W-1:0] d [D];
        always_ff @(posedge clk or negedge reset)
            if (!reset) begin
                for (int i = 0; i < D; i++) v[i] <= 1'b0;
            end else if (enable) begin
                v[0] <= iv;
                for (int i = 1; i < D; i++) v[i] <= v[i-1];
            end
        always_ff @(posedge clk)
            if (enable) begin
                d[0] <= id;
                for (int i = 1; i < D; i++) d[i] <= d[i-1];
            end
        assign ov = v[D-1];
        assign od = d[D-1];
    end
endmodule

module multiply_accumulate_pipe #(
    parameter int IN_M_WIDTH      = 10,
    parameter int IN_A_WIDTH      = 20,
    parameter int ACC_WIDTH       = 24,
    parameter int OUT_WIDTH       = 21,
    parameter int INPUT_REG_DEPTH = 1,
    parameter int MULT_PIPE_DEPTH = 1,
    parameter int SHIFT           = 0,
    parameter int SATURATE        = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         inReady,
    input  logic                         inLast,
    input  logic                         mode,
    input  logic signed [IN_M_WIDTH-1:0] A,
    input  logic signed [IN_M_WIDTH-1:0] B,
    input  logic signed [IN_A_WIDTH-1:0] C,
    output logic                         outReady,
    output logic                         earlyOutReady,
    output logic signed [OUT_WIDTH-1:0]  RES,
    output logic                         overflow
);
    localparam int PW = 2 * IN_M_WIDTH;
    localparam int TW = 2 + IN_A_WIDTH;
    localparam int RW = ACC_WIDTH + 1;
    localparam logic signed [RW-1:0] HALF = RW'(SHIFT > 0 ? 2 ** (SHIFT - 1) : 0);
    localparam logic [OUT_WIDTH-1:0] SMIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] SMAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};

    logic                         v1, v2, m2, l2, emit, wrap, fits;
    logic [TW+PW-1:0]             d1, d2;
    logic signed [IN_M_WIDTH-1:0] a1, b1;
    logic signed [PW-1:0]         prod, p2;
    logic signed [IN_A_WIDTH-1:0] c2;
    logic signed [ACC_WIDTH-1:0]  acc, base, pe, sum;
    logic signed [RW-1:0]         rx, rr;
    logic [OUT_WIDTH-1:0]         conv;
    logic                         run_open, run_ovf;

    // tags {mode, inLast, C} ride alongside the operands so they stay aligned with their product
    mac_delay #(.W(TW + PW), .D(INPUT_REG_DEPTH)) u_in (
        .clk(clk), .reset(reset), .enable(enable),
        .iv(inReady), .id({mode, inLast, C, A, B}), .ov(v1), .od(d1)
    );

    assign a1   = d1[PW-1:IN_M_WIDTH];
    assign b1   = d1[IN_M_WIDTH-1:0];
    assign prod = PW'(a1) * PW'(b1);

    mac_delay #(.W(TW + PW), .D(MULT_PIPE_DEPTH)) u_mul (
        .clk(clk), .reset(reset), .enable(enable),
        .iv(v1), .id({d1[TW+PW-1:PW], prod}), .ov(v2), .od(d2)
    );

    assign m2 = d2[TW+PW-1];
    assign l2 = d2[TW+PW-2];
    assign c2 = d2[PW +: IN_A_WIDTH];
    assign p2 = d2[PW-1:0];

    // an open run continues from acc; MADD and run-opening MACC start from C
    assign base = (m2 & run_open) ? acc : ACC_WIDTH'(c2);
    assign pe   = ACC_WIDTH'(p2);
    assign sum  = base + pe;
    assign wrap = (base[ACC_WIDTH-1] == pe[ACC_WIDTH-1]) & (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
    assign emit = v2 & (~m2 | l2);

    // one guard bit keeps the rounding add from wrapping before the shift
    assign rx   = RW'(sum);
    assign rr   = (rx + HALF) >>> SHIFT;
    assign fits = (&rr[RW-1:OUT_WIDTH-1]) | ~(|rr[RW-1:OUT_WIDTH-1]);
    assign conv = (SATURATE == 0 || fits) ? rr[OUT_WIDTH-1:0] : rr[RW-1] ? SMIN : SMAX;

    assign earlyOutReady = reset & emit;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            acc      <= '0;
            run_open <= 1'b0;
            run_ovf  <= 1'b0;
            RES      <= '0;
            outReady <= 1'b0;
            overflow <= 1'b0;
        end else if (enable) begin
            outReady <= emit;
            if (emit) begin
                RES      <= conv;
                overflow <= ~fits | (m2 & (run_ovf | wrap));
            end
            if (v2 & m2) begin
                acc      <= sum;
                run_open <= ~l2;
                run_ovf  <= ~l2 & (run_ovf | wrap);
            end
        end
endmodule
